// File: rtl/game_pkg.sv
// Shared encodings and datapath widths for the frog-crossing game sequencer.
package game_pkg;

  localparam int POS_W   = 12;
  localparam int SCORE_W = 8;
  localparam int LIVES_W = 2;

  typedef enum logic [1:0] {
    ST_ATTRACT = 2'd0,
    ST_PLAY    = 2'd1,
    ST_HIT     = 2'd2,
    ST_OVER    = 2'd3
  } state_e;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous button, followed by a rising-edge pulse.
module btn_sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_rise
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;
  logic       prev_q;
  logic       prev_d;

  // next-state for the synchroniser chain and the edge-detect history
  always_comb begin
    sync_d = {sync_q[0], i_btn};
    prev_d = sync_q[1];
  end

  // synchroniser and history registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign o_rise = sync_q[1] & ~prev_q;

endmodule

// File: rtl/frog_game_ctrl.sv
// Frame-rate game sequencer: frog position, game state, lives and score,
// with per-frame collision gathering and obstacle animation gating.
module frog_game_ctrl
  import game_pkg::*;
#(
  parameter int START_Y    = 465,
  parameter int STEP       = 30,
  parameter int GOAL_Y     = 45,
  parameter int LIVES      = 3,
  parameter int HIT_FRAMES = 60
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_pix_stb,
  input  logic               i_animate,
  input  logic               i_up_btn,
  input  logic               i_down_btn,
  input  logic               i_hit,
  output logic [POS_W-1:0]   o_frog_y,
  output logic [1:0]         o_state,
  output logic [LIVES_W-1:0] o_lives,
  output logic [SCORE_W-1:0] o_score,
  output logic               o_run
);

  localparam int TMR_W = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES) : 1;

  localparam logic [POS_W-1:0]   START_Y_C   = POS_W'(START_Y);
  localparam logic [POS_W-1:0]   STEP_C      = POS_W'(STEP);
  localparam logic [POS_W-1:0]   UP_LIMIT_C  = POS_W'(GOAL_Y + STEP);
  localparam logic [POS_W:0]     START_Y_W_C = (POS_W+1)'(START_Y);
  localparam logic [POS_W:0]     STEP_W_C    = (POS_W+1)'(STEP);
  localparam logic [LIVES_W-1:0] LIVES_C     = LIVES_W'(LIVES);
  localparam logic [TMR_W-1:0]   HIT_INIT_C  = TMR_W'(HIT_FRAMES - 1);

  state_e             state_q, state_d;
  logic [POS_W-1:0]   y_q, y_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               run_q, run_d;
  logic               up_req_q, up_req_d;
  logic               down_req_q, down_req_d;
  logic               hit_q, hit_d;
  logic               hit_now_s;
  logic               up_rise_s;
  logic               down_rise_s;

  btn_sync_edge u_up_sync (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_btn  (i_up_btn),
    .o_rise (up_rise_s)
  );

  btn_sync_edge u_down_sync (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_btn  (i_down_btn),
    .o_rise (down_rise_s)
  );

  // per-frame request/collision bookkeeping and the frame-rate FSM
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    lives_d = lives_q;
    score_d = score_q;
    timer_d = timer_q;

    // a hit coinciding with the animate pulse still belongs to this frame
    hit_now_s = hit_q | (i_hit & i_pix_stb);
    if (i_animate || (state_q != ST_PLAY)) begin
      hit_d = 1'b0;
    end else begin
      hit_d = hit_now_s;
    end

    // an edge arriving with animate survives into the next frame
    if (state_q == ST_HIT) begin
      up_req_d   = 1'b0;
      down_req_d = 1'b0;
    end else if (i_animate) begin
      up_req_d   = up_rise_s;
      down_req_d = down_rise_s;
    end else begin
      up_req_d   = up_req_q | up_rise_s;
      down_req_d = down_req_q | down_rise_s;
    end

    if (i_animate) begin
      case (state_q)
        ST_ATTRACT: begin
          if (up_req_q || down_req_q) begin
            state_d = ST_PLAY;
            lives_d = LIVES_C;
            score_d = {SCORE_W{1'b0}};
          end else begin
            y_d = START_Y_C;
          end
        end
        ST_PLAY: begin
          if (hit_now_s) begin
            state_d = ST_HIT;
            timer_d = HIT_INIT_C;
            if (lives_q != {LIVES_W{1'b0}}) begin
              lives_d = lives_q - LIVES_W'(1);
            end else begin
              lives_d = {LIVES_W{1'b0}};
            end
          end else if (up_req_q && down_req_q) begin
            y_d = y_q;
          end else if (up_req_q) begin
            if (y_q <= UP_LIMIT_C) begin
              y_d = START_Y_C;
              if (score_q != {SCORE_W{1'b1}}) begin
                score_d = score_q + SCORE_W'(1);
              end else begin
                score_d = score_q;
              end
            end else begin
              y_d = y_q - STEP_C;
            end
          end else if (down_req_q) begin
            if (({1'b0, y_q} + STEP_W_C) <= START_Y_W_C) begin
              y_d = y_q + STEP_C;
            end else begin
              y_d = y_q;
            end
          end else begin
            y_d = y_q;
          end
        end
        ST_HIT: begin
          if (timer_q != {TMR_W{1'b0}}) begin
            timer_d = timer_q - TMR_W'(1);
          end else if (lives_q == {LIVES_W{1'b0}}) begin
            state_d = ST_OVER;
          end else begin
            state_d = ST_PLAY;
            y_d     = START_Y_C;
          end
        end
        ST_OVER: begin
          if (up_req_q || down_req_q) begin
            state_d = ST_ATTRACT;
            y_d     = START_Y_C;
          end else begin
            state_d = ST_OVER;
          end
        end
        default: begin
          state_d = ST_ATTRACT;
          y_d     = START_Y_C;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    run_d = (state_d == ST_ATTRACT) || (state_d == ST_PLAY);
  end

  // game state registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_ATTRACT;
      y_q        <= START_Y_C;
      lives_q    <= LIVES_C;
      score_q    <= {SCORE_W{1'b0}};
      timer_q    <= {TMR_W{1'b0}};
      run_q      <= 1'b1;
      up_req_q   <= 1'b0;
      down_req_q <= 1'b0;
      hit_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      y_q        <= y_d;
      lives_q    <= lives_d;
      score_q    <= score_d;
      timer_q    <= timer_d;
      run_q      <= run_d;
      up_req_q   <= up_req_d;
      down_req_q <= down_req_d;
      hit_q      <= hit_d;
    end
  end

  assign o_frog_y = y_q;
  assign o_state  = state_q;
  assign o_lives  = lives_q;
  assign o_score  = score_q;
  assign o_run    = run_q;

endmodule

// File: tb/tb_frog_game_ctrl.sv
// Directed bench for frog_game_ctrl: a frame-by-frame vector table plus
// hand-written sequences for held/late presses and asynchronous reset.
module tb_frog_game_ctrl;

  localparam logic [1:0] S_ATT  = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_HIT  = 2'd2;
  localparam logic [1:0] S_OVER = 2'd3;

  typedef struct {
    logic        up;
    logic        dn;
    logic [1:0]  hit;   // 0 none, 1 mid-frame, 2 on the animate cycle
    logic [1:0]  st;
    logic [11:0] y;
    logic [1:0]  lives;
    logic [7:0]  score;
    logic        run;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_stb;
  logic        animate;
  logic        up_btn;
  logic        down_btn;
  logic        hit;
  logic [11:0] frog_y;
  logic [1:0]  state;
  logic [1:0]  lives;
  logic [7:0]  score;
  logic        run;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  frog_game_ctrl #(.HIT_FRAMES(4)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_pix_stb  (pix_stb),
    .i_animate  (animate),
    .i_up_btn   (up_btn),
    .i_down_btn (down_btn),
    .i_hit      (hit),
    .o_frog_y   (frog_y),
    .o_state    (state),
    .o_lives    (lives),
    .o_score    (score),
    .o_run      (run)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic add(input logic u, input logic d, input logic [1:0] h, input logic [1:0] st,
                     input int y, input int lv, input int sc, input logic r);
    vec_t v;
    v.up = u; v.dn = d; v.hit = h; v.st = st;
    v.y = 12'(y); v.lives = 2'(lv); v.score = 8'(sc); v.run = r;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [1:0] st, input int y, input int lv,
                     input int sc, input logic r);
    logic [24:0] got;
    logic [24:0] exp;
    got = {state, frog_y, lives, score, run};
    exp = {st, 12'(y), 2'(lv), 8'(sc), r};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got state=%0d y=%0d lives=%0d score=%0d run=%0b, want state=%0d y=%0d lives=%0d score=%0d run=%0b",
               name, state, frog_y, lives, score, run, st, y, lv, sc, r);
    end
  endtask

  task automatic pulse_animate();
    animate = 1'b1;
    tick(1);
    animate = 1'b0;
  endtask

  // one frame: optional press, a stray unqualified hit, optional real hit, then animate
  task automatic frame(input logic u, input logic d, input logic [1:0] h);
    up_btn = u; down_btn = d;
    tick(1);
    hit = 1'b1; pix_stb = 1'b0;
    tick(1);
    hit = 1'b0;
    if (h == 2'd1) begin
      hit = 1'b1; pix_stb = 1'b1;
      tick(1);
      hit = 1'b0; pix_stb = 1'b0;
    end else begin
      pix_stb = 1'b1;
      tick(1);
      pix_stb = 1'b0;
    end
    up_btn = 1'b0; down_btn = 1'b0;
    tick(3);
    if (h == 2'd2) begin
      hit = 1'b1; pix_stb = 1'b1;
    end else begin
      hit = 1'b0;
    end
    pulse_animate();
    hit = 1'b0; pix_stb = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pix_stb = 1'b0; animate = 1'b0;
    up_btn = 1'b0; down_btn = 1'b0; hit = 1'b0;

    add(0,0,0, S_ATT, 465,3,0,1);
    add(1,0,0, S_PLAY,465,3,0,1);
    add(1,0,0, S_PLAY,435,3,0,1);
    add(0,1,0, S_PLAY,465,3,0,1);
    add(0,1,0, S_PLAY,465,3,0,1);
    add(1,0,0, S_PLAY,435,3,0,1);
    add(1,1,0, S_PLAY,435,3,0,1);
    add(0,1,0, S_PLAY,465,3,0,1);
    for (int k = 1; k <= 13; k++) add(1,0,0, S_PLAY, 465 - 30*k, 3,0,1);
    add(1,0,0, S_PLAY,465,3,1,1);
    add(1,0,0, S_PLAY,435,3,1,1);
    add(1,0,1, S_HIT, 435,2,1,0);
    add(0,0,0, S_HIT, 435,2,1,0);
    add(1,0,0, S_HIT, 435,2,1,0);
    add(0,0,0, S_HIT, 435,2,1,0);
    add(1,0,0, S_PLAY,465,2,1,1);
    add(0,0,0, S_PLAY,465,2,1,1);
    add(1,0,2, S_HIT, 465,1,1,0);
    for (int k = 0; k < 3; k++) add(0,0,0, S_HIT,465,1,1,0);
    add(0,0,0, S_PLAY,465,1,1,1);
    add(0,0,1, S_HIT, 465,0,1,0);
    for (int k = 0; k < 3; k++) add(0,0,0, S_HIT,465,0,1,0);
    add(0,0,0, S_OVER,465,0,1,0);
    add(0,0,0, S_OVER,465,0,1,0);
    add(1,0,0, S_ATT, 465,0,1,1);
    add(0,1,0, S_PLAY,465,3,0,1);

    tick(2);
    chk("reset_values", S_ATT, 465, 3, 0, 1'b1);
    rst = 1'b0;
    tick(2);

    for (int i = 0; i < vecs.size(); i++) begin
      frame(vecs[i].up, vecs[i].dn, vecs[i].hit);
      chk($sformatf("vec%0d", i), vecs[i].st, vecs[i].y, vecs[i].lives, vecs[i].score, vecs[i].run);
    end

    // held press: one move only, nothing changes before animate
    up_btn = 1'b1;
    tick(6);
    chk("held_before_animate", S_PLAY, 465, 3, 0, 1'b1);
    pulse_animate();
    chk("held_first_frame", S_PLAY, 435, 3, 0, 1'b1);
    tick(6);
    pulse_animate();
    chk("held_second_frame", S_PLAY, 435, 3, 0, 1'b1);
    up_btn = 1'b0;
    tick(4);

    // press rising together with animate is served next frame
    up_btn = 1'b1; animate = 1'b1;
    tick(1);
    animate = 1'b0;
    chk("late_press_not_yet", S_PLAY, 435, 3, 0, 1'b1);
    tick(1);
    up_btn = 1'b0;
    tick(5);
    pulse_animate();
    chk("late_press_next_frame", S_PLAY, 405, 3, 0, 1'b1);

    // asynchronous reset mid-HIT, with bounce while reset is held
    frame(1'b0, 1'b0, 2'd1);
    chk("hit_before_reset", S_HIT, 405, 2, 0, 1'b0);
    tick(1);
    #3 rst = 1'b1;
    #1 chk("async_reset_mid_hit", S_ATT, 465, 3, 0, 1'b1);
    up_btn = 1'b1; tick(1);
    up_btn = 1'b0; tick(1);
    up_btn = 1'b1; tick(2);
    up_btn = 1'b0; tick(3);
    rst = 1'b0;
    tick(2);
    frame(1'b0, 1'b0, 2'd0);
    chk("no_move_after_bounce", S_ATT, 465, 3, 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frog_game_ctrl.md
# frog_game_ctrl

Game sequencer for the frog-crossing VGA design. Sits between the button inputs, the VGA timing generator's frame strobe and the obstacle/frog renderers. Owns the frog's vertical position, game state, lives and score, and gates obstacle animation. Collisions are gathered per frame from a pixel-level overlap flag; all decisions are taken once per frame on the animate pulse.

## Interface
- START_Y, 465: frog centre y at spawn.
- STEP, 30: pixels moved per accepted button press.
- GOAL_Y, 45: reaching y ≤ GOAL_Y counts as a crossing.
- LIVES, 3: lives per game, 1..3.
- HIT_FRAMES, 60: frames frozen after a collision, ≥1.
- i_clk  in  1  system clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_pix_stb  in  1  pixel strobe; qualifies i_hit.
- i_animate  in  1  one-cycle end-of-frame pulse.
- i_up_btn  in  1  raw up button, active-high, asynchronous.
- i_down_btn  in  1  raw down button, active-high, asynchronous.
- i_hit  in  1  frog/obstacle overlap at the current pixel.
- o_frog_y  out  12  frog centre y, unsigned.
- o_state  out  2  0 ATTRACT, 1 PLAY, 2 HIT, 3 OVER.
- o_lives  out  2  lives remaining.
- o_score  out  8  crossings this game, saturating at 255.
- o_run  out  1  obstacle animation enable.

## Operation
- Buttons: 2-flop synchroniser, then rising-edge detect. Each edge sets a pending bit (up_req/down_req). Every i_animate clears both pending bits, in every state.
- Hit accumulator: hit_flag |= i_hit & i_pix_stb. It is evaluated and cleared on i_animate. It is held clear outside PLAY. A hit in the animate cycle itself counts toward the current frame.
- ATTRACT: o_run=1, frog at START_Y. On animate with either request pending: go to PLAY, lives=LIVES, score=0. The request is consumed and does not move the frog.
- PLAY: o_run=1. On animate:
  - if hit_flag: go to HIT, lives−1, hit_timer=HIT_FRAMES−1, frog y unchanged.
  - else if up_req && down_req: no move.
  - else if up_req: if y ≤ GOAL_Y+STEP, then score+1 (saturating) and y=START_Y. Otherwise y−STEP.
  - else if down_req: if y+STEP ≤ START_Y, then y+STEP. Otherwise no move.
  - Hit has priority over any move.
- HIT: o_run=0, frog frozen, requests discarded. On animate:
  - if hit_timer≠0: decrement.
  - if hit_timer=0 and lives=0: go to OVER.
  - if hit_timer=0 and lives≠0: go to PLAY with y=START_Y.
- OVER: o_run=0, score and lives held. On animate with a request pending: go to ATTRACT, y=START_Y.
- Arithmetic: y is 12-bit unsigned. The up-move compares against GOAL_Y+STEP before subtracting, so y never underflows. Lives never go below 0.

## Timing
- Reset values: o_state=ATTRACT, o_frog_y=START_Y, o_lives=LIVES, o_score=0, o_run=1. Pending bits, hit_flag, hit_timer and synchronisers all clear.
- Reset is asynchronous: outputs take reset values without a clock edge, at any point including mid-HIT.
- All outputs are registered and change only on the i_clk edge that samples i_animate=1. The one exception is reset.
- Button latency: an edge is registered 3 cycles after the pin rises. A press landing within 3 cycles of animate is acted on at the following frame.
- A press held across frames produces exactly one move.

## Structure
- Shared package game_pkg:
  - state encodings ST_ATTRACT/ST_PLAY/ST_HIT/ST_OVER.
  - widths POS_W=12, SCORE_W=8, LIVES_W=2.
- Sub-module btn_sync_edge: 2-flop synchroniser plus rising-edge pulse. Instantiated once per button.
- Remainder: one FSM with position/lives/score/timer datapath.

## Test plan
Bench parameters: defaults, except HIT_FRAMES=4.
- Reset: outputs 0/465/3/0/run=1. Up press then animate: state=PLAY, y=465, lives=3.
- PLAY moves: up+animate gives y=435; down+animate gives 465; down at 465 stays 465; up and down in the same frame leave y unchanged.
- 14 up frames: after the 13th, y=75; on the 14th, score=1 and y=465.
- Frame with i_hit=1 on one i_pix_stb cycle plus up pending: state=HIT, lives=2, y unchanged, run=0. After 4 more animates: state=PLAY, y=465, run=1.
- Three hits: state=OVER, lives=0, score held. Press: ATTRACT. Press again: PLAY with lives=3, score=0.
- i_rst pulsed between clock edges during HIT: outputs show reset values immediately. A button bounce during reset produces no move.
